// File: rtl/deser_fifo_pkg.sv
// deser_fifo_pkg: FSM states, status counter width and saturating increment shared by deser_fifo_bridge
package deser_fifo_pkg;
   typedef enum logic [1:0] {SHIFT, PARITY, HOLD} deser_state_t;
   localparam int CNT_W = 8;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-clk enable pulse every DIV clocks, first pulse acted on DIV clocks after reset release
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = (cnt == W'(DIV - 1));
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/deser_fifo_bridge.sv
// deser_fifo_bridge: serial-to-parallel deserializer feeding a circular FIFO, tick-enabled on one clock.
// Define PARITY_CHECK_EN to require an even-parity bit after each word and count parity errors.
module deser_fifo_bridge
   import deser_fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int DESER_DIV = 10,
   parameter int QUEUE_DIV = 100,
   parameter int MSB_FIRST = 0,
   localparam int LEN_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              data_in,
   input  logic              write_in,
   input  logic              dequeue_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [LEN_W-1:0]  len,
   output logic              full,
   output logic              empty,
   output logic              deser_busy,
`ifdef PARITY_CHECK_EN
   output logic [CNT_W-1:0]  parity_err_cnt,
`endif
   output logic [CNT_W-1:0]  drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(DATA_W);

   logic d_tick, q_tick;
   deser_state_t state, state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [BW-1:0] bit_cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic bit_in, last_bit, push, pop;
   logic [LEN_W-1:0] len_nxt;

   tick_gen #(.DIV(DESER_DIV)) u_deser_tick (.clk(clk), .reset_n(reset_n), .tick(d_tick));
   tick_gen #(.DIV(QUEUE_DIV)) u_queue_tick (.clk(clk), .reset_n(reset_n), .tick(q_tick));

   assign bit_in     = d_tick && write_in;
   assign last_bit   = (bit_cnt == BW'(DATA_W - 1));
   assign deser_busy = (state == HOLD);
   // a full FIFO still accepts the staged word when the same tick pops
   assign push       = q_tick && deser_busy && (!full || dequeue_in);
   assign pop        = q_tick && dequeue_in && !empty;
   assign len_nxt    = len + LEN_W'(push) - LEN_W'(pop);

`ifdef PARITY_CHECK_EN
   logic par_ok;
   assign par_ok = ~^{shreg, data_in};
`endif

   always_comb begin
      state_nxt = state;
      case (state)
`ifdef PARITY_CHECK_EN
         SHIFT:   if (bit_in && last_bit) state_nxt = PARITY;
         PARITY:  if (bit_in) state_nxt = par_ok ? HOLD : SHIFT;
`else
         SHIFT:   if (bit_in && last_bit) state_nxt = HOLD;
`endif
         HOLD:    if (push) state_nxt = SHIFT;
         default: state_nxt = SHIFT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= SHIFT;
         shreg    <= '0;
         bit_cnt  <= '0;
         drop_cnt <= '0;
`ifdef PARITY_CHECK_EN
         parity_err_cnt <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (state == SHIFT && bit_in) begin
            shreg   <= (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], data_in} : {data_in, shreg[DATA_W-1:1]};
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
         end
         if (deser_busy && bit_in) drop_cnt <= sat_inc(drop_cnt);
`ifdef PARITY_CHECK_EN
         if (state == PARITY && bit_in && !par_ok) parity_err_cnt <= sat_inc(parity_err_cnt);
`endif
      end
   end

   always_ff @(posedge clk)
      if (push) mem[wr] <= shreg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd         <= '0;
         wr         <= '0;
         len        <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= pop;
         if (pop) begin
            data_out <= mem[rd];
            rd       <= rd + 1'b1;
         end
         if (push) wr <= wr + 1'b1;
         len   <= len_nxt;
         full  <= (len_nxt == LEN_W'(DEPTH));
         empty <= (len_nxt == '0);
      end
   end
endmodule
